// File: rtl/conv_frame_writer_if.sv
// ============================================================================
// Module      : conv_frame_writer_if
// Description : Pixel-stream, readback and status bundle for conv_frame_writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_frame_writer_if #(
    parameter int AW = 10
);
    logic [7:0]    pix_i;
    logic          pix_valid;
    logic          clear;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          busy;
    logic          frame_done;
    logic          overflow;
    logic [7:0]    min_o;
    logic [7:0]    max_o;
    logic [AW:0]   wr_count;

    modport master (
        output pix_i, pix_valid, clear, rd_req, rd_addr,
        input  rd_data, rd_valid, busy, frame_done, overflow, min_o, max_o, wr_count
    );

    modport slave (
        input  pix_i, pix_valid, clear, rd_req, rd_addr,
        output rd_data, rd_valid, busy, frame_done, overflow, min_o, max_o, wr_count
    );
endinterface

`default_nettype wire

// File: rtl/conv_frame_writer.sv
// ============================================================================
// Module      : conv_frame_writer
// Description : Captures one filtered frame in raster order with min/max stats,
//               then serves registered random-access readback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_frame_writer #(
    parameter int IM_SIZE = 32,
    parameter int K       = 3,
    parameter int OUT_DIM = IM_SIZE - K + 1,
    parameter int DEPTH   = OUT_DIM * OUT_DIM,
    parameter int AW      = $clog2(DEPTH)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    conv_frame_writer_if.slave  bus
);

    localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_wr_count;
    logic [7:0]    r_min;
    logic [7:0]    r_max;
    logic          r_overflow;
    logic [7:0]    r_rd_data;
    logic          r_rd_valid;
    logic [7:0]    r_mem [DEPTH];

    logic w_wr_en;
    logic w_rd_ok;

    // clear outranks a coincident pixel, and DONE blocks all writes
    assign w_wr_en = bus.pix_valid && !bus.clear && (r_state != S_DONE);
    assign w_rd_ok = bus.rd_req && (r_state == S_DONE) && ({1'b0, bus.rd_addr} < c_DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (bus.pix_valid) w_state_nxt = (DEPTH == 1) ? S_DONE : S_CAPTURE;
                S_CAPTURE: if (bus.pix_valid && (r_wr_ptr == c_LAST)) w_state_nxt = S_DONE;
                S_DONE:    w_state_nxt = S_DONE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_wr_count <= '0;
            r_min      <= 8'hFF;
            r_max      <= 8'h00;
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr   <= '0;
            r_wr_count <= '0;
            r_min      <= 8'hFF;
            r_max      <= 8'h00;
            r_overflow <= 1'b0;
        end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_wr_count != c_DEPTH) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
            // first pixel of a frame seeds both statistics
            if (r_state == S_IDLE) begin
                r_min <= bus.pix_i;
                r_max <= bus.pix_i;
            end else begin
                if (bus.pix_i < r_min) r_min <= bus.pix_i;
                if (bus.pix_i > r_max) r_max <= bus.pix_i;
            end
        end else if ((r_state == S_DONE) && bus.pix_valid) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.pix_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_data <= r_mem[bus.rd_addr];
            end
        end
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.busy       = (r_state == S_CAPTURE);
    assign bus.frame_done = (r_state == S_DONE);
    assign bus.overflow   = r_overflow;
    assign bus.min_o      = r_min;
    assign bus.max_o      = r_max;
    assign bus.wr_count   = r_wr_count;

endmodule

`default_nettype wire

// File: doc/conv_frame_writer.md
# conv_frame_writer

Downstream capture stage for the convolution filter. It takes the filtered pixel stream (one 8-bit pixel per cycle when the filter's write strobe is high) and stores it in raster order in an internal output frame buffer. It tracks frame completion and per-frame min/max statistics. Once the frame is complete, it serves random-access readback to the host or next stage.

## Interface
- IM_SIZE, 32, input image dimension N (image is N×N)
- K, 3, kernel dimension
- OUT_DIM, IM_SIZE-K+1, output frame dimension (30 at defaults)
- DEPTH, OUT_DIM*OUT_DIM, buffer entries (900 at defaults)
- AW, $clog2(DEPTH), address width (10 at defaults)

- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-low reset
- pix_i  input  8  filtered pixel, connected to the filter's data_o
- pix_valid  input  1  pixel strobe, connected to the filter's data_write
- clear  input  1  synchronous frame restart, one-cycle pulse
- rd_req  input  1  readback request
- rd_addr  input  AW  readback address, raster order (row*OUT_DIM+col)
- rd_data  output  8  readback pixel, registered
- rd_valid  output  1  rd_data valid strobe
- busy  output  1  frame capture in progress (state CAPTURE)
- frame_done  output  1  level, full frame stored (state DONE)
- overflow  output  1  sticky, pixel arrived while in DONE
- min_o  output  8  minimum pixel of current frame
- max_o  output  8  maximum pixel of current frame
- wr_count  output  AW+1  pixels stored in current frame

## Operation
- Buffer: DEPTH×8 synchronous RAM, one write port and one registered read port. RAM contents are not reset.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE: wr_ptr=0. On pix_valid, write to addr 0, set wr_ptr=1, min_o=max_o=pix_i, and go to CAPTURE. If DEPTH==1, go straight to DONE.
  - CAPTURE: on each pix_valid, write to wr_ptr and increment wr_ptr. Update min_o/max_o (unsigned compare). When the write lands at DEPTH-1, go to DONE. Gaps in pix_valid are legal; state holds.
  - DONE: writes are blocked. pix_valid sets overflow (sticky) and the pixel is dropped. min_o, max_o and wr_count are frozen.
- clear in any state:
  - go to IDLE; reset wr_ptr, wr_count, min_o=8'hFF, max_o=8'h00 and overflow.
  - If clear and pix_valid occur in the same cycle, clear wins and the pixel is dropped.
- Readback:
  - Accepted only in DONE. rd_req with rd_addr<DEPTH loads rd_data from RAM and pulses rd_valid.
  - rd_req outside DONE, or with rd_addr≥DEPTH, is ignored: rd_valid=0 and rd_data holds its value.
  - Back-to-back reads are supported, one per cycle.
- wr_count equals the number of stored pixels and saturates at DEPTH.
- Reset (rst=0, asynchronous), mid-frame or otherwise:
  - state=IDLE, wr_ptr=0, wr_count=0, rd_data=0, rd_valid=0, busy=0, frame_done=0, overflow=0, min_o=8'hFF, max_o=8'h00.
  - The partial frame is abandoned.

## Timing
- Write: pix_i is sampled on the rising edge where pix_valid=1 and is stored at that edge. wr_count, min_o and max_o update on the same edge and are visible the next cycle.
- busy rises the cycle after the first accepted pixel.
- frame_done rises the cycle after the edge that stores entry DEPTH-1. busy falls on that same cycle.
- Read latency is 1 cycle: for rd_req sampled at edge n, rd_data and rd_valid are valid after edge n+1. rd_valid is high for exactly one cycle per request.
- A read issued on the first DONE cycle returns the pixel just written.
- clear takes effect at the sampling edge. The next cycle shows frame_done=0, busy=0 and overflow=0.
- Reset release is synchronous to clk. The first pixel is accepted no earlier than the first rising edge with rst=1.

## Test plan
- Full frame:
  - Stimulus: reset, then stream 900 pixels with value (i mod 256), one per cycle.
  - Response: frame_done=1 one cycle after the 900th edge; wr_count=900; min_o=0; max_o=255; busy=0.
- Readback:
  - Stimulus: after the full frame, read addresses 0, 1, 899 back-to-back.
  - Response: rd_data=0, 1, 899 mod 256=131 on three consecutive cycles; rd_valid high for each.
  - Stimulus: rd_addr=900.
  - Response: rd_valid stays 0.
- Gapped stream and statistics:
  - Stimulus: 900 pixels with pix_valid toggling every other cycle; all pixels 8'h40 except one 8'h07 and one 8'hF0.
  - Response: frame_done after the 900th valid pixel; min_o=8'h07; max_o=8'hF0.
- Overflow and clear:
  - Stimulus: pix_valid=1 in DONE with pix_i=8'hAA.
  - Response: overflow=1; read of address 0 is unchanged; wr_count=900.
  - Stimulus: pulse clear together with pix_valid.
  - Response: IDLE, overflow=0, wr_count=0, and that pixel is not stored.
- Reset mid-frame:
  - Stimulus: assert rst=0 asynchronously (between edges) after 450 pixels.
  - Response: outputs go to reset values immediately, without waiting for a clock edge.
  - Stimulus: a new 900-pixel frame.
  - Response: frame_done after exactly 900 pixels; readback matches the new frame.
- Read gating:
  - Stimulus: rd_req during IDLE and during CAPTURE.
  - Response: rd_valid=0 and rd_data holds its prior value.
